// File: rtl/preparser_window.sv
// Overlapping-window former for the preparser: each 16-byte beat is emitted together with the
// first LA_BYTES bytes of its successor. Optional stall counter enabled by PREPARSER_WINDOW_STALL_CNT_EN.
`timescale 1ns/1ps

module preparser_window #(
    parameter int LA_BYTES = 2,
    parameter int ADDR_W   = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [127:0]                 in_data,
    input  logic [4:0]                   in_len,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [8*(16+LA_BYTES)-1:0]   out_data,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [4:0]                   out_len,
    output logic                         out_last,
`ifdef PREPARSER_WINDOW_STALL_CNT_EN
    output logic [31:0]                  stall_cnt,
`endif
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int LA_W = 8 * LA_BYTES;

    logic              cur_valid;
    logic [127:0]      cur_data;
    logic [4:0]        cur_len;
    logic              cur_last;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] naddr;

    logic       load;
    logic [4:0] beat_len;

    // A non-last window needs its successor's leading bytes, so it waits for in_valid.
    assign out_valid = cur_valid & (cur_last | in_valid);
    assign in_ready  = ~cur_valid | out_ready;
    assign load      = in_valid & in_ready;

    assign out_data  = cur_last ? {cur_data, {LA_W{1'b0}}}
                                : {cur_data, in_data[127 -: LA_W]};
    assign out_addr  = cur_addr;
    assign out_len   = cur_len;
    assign out_last  = cur_last;

    always_comb begin
        beat_len = 5'd16;
        if (in_last && in_len != 5'd0)
            beat_len = in_len;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_valid <= 1'b0;
            cur_data  <= '0;
            cur_len   <= '0;
            cur_last  <= 1'b0;
            cur_addr  <= '0;
            naddr     <= '0;
        end else if (load) begin
            // An accepted beat always replaces cur; in_ready guarantees any old window fires now.
            cur_valid <= 1'b1;
            cur_data  <= in_data;
            cur_len   <= beat_len;
            cur_last  <= in_last;
            cur_addr  <= naddr;
            naddr     <= in_last ? '0 : naddr + ADDR_W'(16);
        end else if (out_valid && out_ready) begin
            cur_valid <= 1'b0;
        end
    end

`ifdef PREPARSER_WINDOW_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_preparser_window.sv
// Self-checking bench for preparser_window: directed scenarios plus randomized traffic
// compared against a beat-level window model.
`timescale 1ns/1ps

module tb_preparser_window;

    localparam int LA_BYTES = 2;
    localparam int LA_W     = 8 * LA_BYTES;
    localparam int WIN_W    = 8 * (16 + LA_BYTES);

    typedef struct packed {
        logic [127:0] data;
        logic [4:0]   len;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [WIN_W-1:0] data;
        logic [16:0]      addr;
        logic [4:0]       len;
        logic             last;
    } window_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [127:0]     in_data = '0;
    logic [4:0]       in_len = '0;
    logic             in_last = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIN_W-1:0] out_data;
    logic [16:0]      out_addr;
    logic [4:0]       out_len;
    logic             out_last;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef PREPARSER_WINDOW_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    preparser_window #(.LA_BYTES(LA_BYTES), .ADDR_W(17)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_len   (out_len),
        .out_last  (out_last),
`ifdef PREPARSER_WINDOW_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int retries = 0;

    beat_t   stim_q[$];
    window_t exp_q[$];
    window_t got_q[$];
    int      got_cyc[$];

    // Reference model: a window is known once the next beat arrives, or immediately for a last beat.
    beat_t m_pend;
    bit    m_pend_v;
    int    m_pend_addr;
    int    m_naddr;

    task automatic model_reset();
        m_pend_v = 0;
        m_naddr  = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input beat_t b);
        window_t w;
        int a;
        a = m_naddr;
        m_naddr = b.last ? 0 : (m_naddr + 16) % (1 << 17);
        if (m_pend_v) begin
            w.data = {m_pend.data, b.data[127 -: LA_W]};
            w.addr = m_pend_addr[16:0];
            w.len  = 5'd16;
            w.last = 1'b0;
            exp_q.push_back(w);
            m_pend_v = 0;
        end
        if (b.last) begin
            w.data = {b.data, {LA_W{1'b0}}};
            w.addr = a[16:0];
            w.len  = (b.len == 5'd0) ? 5'd16 : b.len;
            w.last = 1'b1;
            exp_q.push_back(w);
        end else begin
            m_pend      = b;
            m_pend_addr = a;
            m_pend_v    = 1;
        end
    endtask

    function automatic logic [127:0] ramp(input int base);
        logic [127:0] d;
        for (int k = 0; k < 16; k++)
            d[127 - 8*k -: 8] = 8'(base + k);
        return d;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive at posedge+1, sample at negedge, return at next posedge+1.
    task automatic cycle(input bit v, input logic [127:0] d, input logic [4:0] len,
                         input bit last, input bit rdy, output bit acc);
        in_valid  = v;
        in_data   = d;
        in_len    = len;
        in_last   = last;
        out_ready = rdy;
        @(negedge clk);
        if (out_valid && out_ready) begin
            got_q.push_back(window_t'{out_data, out_addr, out_len, out_last});
            got_cyc.push_back(cyc);
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        in_valid  = 0;
        in_last   = 0;
        out_ready = 0;
        rst_n     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        got_q.delete();
        got_cyc.delete();
        model_reset();
        cyc = 0;
    endtask

    task automatic run_stim(input int gap_pct, input int stall_pct);
        bit acc, v, r;
        int n;
        retries = 0;
        foreach (stim_q[i]) begin
            model_push(stim_q[i]);
            acc = 0;
            n = 0;
            while (!acc && n < 200) begin
                v = ($urandom_range(99) >= gap_pct);
                r = ($urandom_range(99) >= stall_pct);
                if (v)
                    cycle(1, stim_q[i].data, stim_q[i].len, stim_q[i].last, r, acc);
                else
                    cycle(0, rand128(), 5'($urandom_range(31)), 1'($urandom_range(1)), r, acc);
                if (v && !acc)
                    retries++;
                n++;
            end
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL stim_timeout: beat %0d not accepted, got in_ready=%b after %0d cycles, required acceptance", i, in_ready, n);
            end
        end
        for (int k = 0; k < 3; k++)
            cycle(0, rand128(), 5'd0, 1'b0, 1'b1, acc);
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 ||
            out_len !== 5'd0 || out_addr !== 17'd0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b ready=%b last=%b len=%0d addr=%h, required 0 1 0 0 0",
                     out_valid, in_ready, out_last, out_len, out_addr);
        end
`ifdef PREPARSER_WINDOW_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_stall_cnt: got %0d, required 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        window_t e0, e1;
        apply_reset();
        stim_q.delete();
        stim_q.push_back(beat_t'{ramp(8'h00), 5'd16, 1'b0});
        stim_q.push_back(beat_t'{ramp(8'h10), 5'd16, 1'b1});
        run_stim(0, 0);
        e0 = window_t'{144'h000102030405060708090a0b0c0d0e0f1011, 17'h00000, 5'd16, 1'b0};
        e1 = window_t'{144'h101112131415161718191a1b1c1d1e1f0000, 17'h00010, 5'd16, 1'b1};
        tests++;
        if (got_q.size() !== 2) begin
            fails++;
            $display("FAIL basic_count: got %0d windows, required 2", got_q.size());
        end else begin
            tests++;
            if (got_q[0] !== e0) begin
                fails++;
                $display("FAIL basic_win0: got %h/%h/%0d/%b, required %h/%h/%0d/%b", got_q[0].data, got_q[0].addr,
                         got_q[0].len, got_q[0].last, e0.data, e0.addr, e0.len, e0.last);
            end
            tests++;
            if (got_q[1] !== e1) begin
                fails++;
                $display("FAIL basic_win1: got %h/%h/%0d/%b, required %h/%h/%0d/%b", got_q[1].data, got_q[1].addr,
                         got_q[1].len, got_q[1].last, e1.data, e1.addr, e1.len, e1.last);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        stim_q.delete();
        for (int k = 0; k < 4; k++)
            stim_q.push_back(beat_t'{rand128(), 5'd16, k == 3});
        run_stim(0, 0);
        tests++;
        if (retries !== 0) begin
            fails++;
            $display("FAIL b2b_in_ready: got %0d refused beats, required 0", retries);
        end
        tests++;
        if (got_q.size() !== 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d windows, required 4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (got_q[k] !== exp_q[k] || got_q[k].addr !== 17'(16 * k) || got_cyc[k] !== got_cyc[0] + k) begin
                    fails++;
                    $display("FAIL b2b_win%0d: got addr=%h cyc=%0d data=%h, required addr=%h cyc=%0d data=%h", k,
                             got_q[k].addr, got_cyc[k], got_q[k].data, 17'(16 * k), got_cyc[0] + k, exp_q[k].data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b;
        logic [WIN_W-1:0] exp_data;
        bit acc;
        apply_reset();
        a = rand128();
        b = rand128();
        exp_data = {a, b[127 -: LA_W]};
        cycle(1, a, 5'd16, 1'b0, 1'b1, acc);
        in_valid  = 1;
        in_data   = b;
        in_len    = 5'd16;
        in_last   = 0;
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_data || out_addr !== 17'd0) begin
                fails++;
                $display("FAIL stall_hold%0d: got valid=%b ready=%b addr=%h data=%h, required 1 0 00000 %h",
                         k, out_valid, in_ready, out_addr, out_data, exp_data);
            end
            @(posedge clk);
            #1;
        end
`ifdef PREPARSER_WINDOW_STALL_CNT_EN
        tests++;
        if (stall_cnt !== 32'd5) begin
            fails++;
            $display("FAIL stall_cnt: got %0d, required 5", stall_cnt);
        end
`endif
        cycle(1, b, 5'd16, 1'b0, 1'b1, acc);
        tests++;
        if (!acc || got_q.size() !== 1 || got_q[0].data !== exp_data) begin
            fails++;
            $display("FAIL stall_release: got acc=%b windows=%0d, required acc=1 windows=1 with held data", acc, got_q.size());
        end
    endtask

    task automatic test_short_last();
        apply_reset();
        stim_q.delete();
        stim_q.push_back(beat_t'{rand128(), 5'd3,  1'b0});
        stim_q.push_back(beat_t'{rand128(), 5'd7,  1'b1});
        stim_q.push_back(beat_t'{rand128(), 5'd9,  1'b0});
        stim_q.push_back(beat_t'{rand128(), 5'd16, 1'b1});
        run_stim(0, 0);
        tests++;
        if (got_q.size() !== 4) begin
            fails++;
            $display("FAIL short_count: got %0d windows, required 4", got_q.size());
        end else begin
            tests++;
            if (got_q[1].len !== 5'd7 || got_q[1].data[LA_W-1:0] !== '0 || got_q[1].last !== 1'b1) begin
                fails++;
                $display("FAIL short_last: got len=%0d la=%h last=%b, required 7 0 1",
                         got_q[1].len, got_q[1].data[LA_W-1:0], got_q[1].last);
            end
            tests++;
            if (got_q[2].addr !== 17'd0) begin
                fails++;
                $display("FAIL short_next_addr: got %h, required 00000", got_q[2].addr);
            end
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (got_q[k] !== exp_q[k]) begin
                    fails++;
                    $display("FAIL short_win%0d: got %h/%h/%0d/%b, required %h/%h/%0d/%b", k, got_q[k].data, got_q[k].addr,
                             got_q[k].len, got_q[k].last, exp_q[k].data, exp_q[k].addr, exp_q[k].len, exp_q[k].last);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int bad;
        apply_reset();
        stim_q.delete();
        for (int k = 0; k < 8194; k++)
            stim_q.push_back(beat_t'{rand128(), 5'($urandom_range(31)), 1'b0});
        run_stim(0, 0);
        tests++;
        if (got_q.size() !== 8193) begin
            fails++;
            $display("FAIL wrap_count: got %0d windows, required 8193", got_q.size());
        end else begin
            tests++;
            if (got_q[8191].addr !== 17'h1FFF0 || got_q[8192].addr !== 17'h00000) begin
                fails++;
                $display("FAIL wrap_addr: got %h then %h, required 1fff0 then 00000", got_q[8191].addr, got_q[8192].addr);
            end
            bad = 0;
            for (int k = 0; k < 8193; k++)
                if (got_q[k] !== exp_q[k]) bad++;
            tests++;
            if (bad !== 0) begin
                fails++;
                $display("FAIL wrap_windows: got %0d differing windows, required 0", bad);
            end
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        apply_reset();
        cycle(1, rand128(), 5'd16, 1'b0, 1'b1, acc);
        in_valid  = 1;
        in_data   = rand128();
        out_ready = 0;
        #2;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: got out_valid=%b, required 1", out_valid);
        end
        rst_n = 0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== 17'd0 || out_len !== 5'd0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL areset_now: got valid=%b ready=%b addr=%h len=%0d last=%b, required 0 1 0 0 0",
                     out_valid, in_ready, out_addr, out_len, out_last);
        end
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        got_q.delete();
        got_cyc.delete();
        model_reset();
        stim_q.delete();
        stim_q.push_back(beat_t'{rand128(), 5'd16, 1'b0});
        stim_q.push_back(beat_t'{rand128(), 5'd11, 1'b1});
        run_stim(0, 0);
        tests++;
        if (got_q.size() !== 2 || got_q[0] !== exp_q[0] || got_q[0].addr !== 17'd0 || got_q[1] !== exp_q[1]) begin
            fails++;
            $display("FAIL areset_after: got %0d windows first addr=%h, required 2 windows first addr=00000 matching model",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].addr : 17'h1FFFF);
        end
    endtask

    task automatic test_random();
        int n;
        apply_reset();
        stim_q.delete();
        for (int k = 0; k < 400; k++)
            stim_q.push_back(beat_t'{rand128(), 5'($urandom_range(16)), (k == 399) || ($urandom_range(4) == 0)});
        run_stim(30, 30);
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL random_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            tests++;
            if (got_q[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL random_win%0d: got %h/%h/%0d/%b, required %h/%h/%0d/%b", k, got_q[k].data, got_q[k].addr,
                         got_q[k].len, got_q[k].last, exp_q[k].data, exp_q[k].addr, exp_q[k].len, exp_q[k].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_short_last();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/preparser_window.md
Name: preparser_window

Overview:
- Upstream feeder of the preparser stage.
- Takes a stream of 16-byte input beats and forms overlapping windows for the token scanner. Each window is the current 16 bytes plus the first LA_BYTES bytes of the following beat (144 bits at defaults).
- Tags each window with its block-relative byte address and a last/length qualifier.
- One beat of lookahead is held internally so a window can be emitted only once its successor is known.

Parameters:
- LA_BYTES, 2: lookahead bytes appended from the next beat; window width is 8*(16+LA_BYTES).
- ADDR_W, 17: byte-address width; the address wraps modulo 2^ADDR_W (128 KB block).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  128  input beat; byte 0 in bits [127:120]
- in_len  input  5  valid bytes in beat (1..16); sampled only when in_last=1, otherwise treated as 16
- in_last  input  1  final beat of the compressed block
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- out_data  output  8*(16+LA_BYTES)  window; current beat in the top 128 bits, lookahead bytes below
- out_addr  output  ADDR_W  byte address of window byte 0 within the block
- out_len  output  5  valid bytes in the 16-byte main part
- out_last  output  1  window is the final one of the block
- out_valid  output  1  window valid
- out_ready  input  1  downstream accept; transfer when out_valid & out_ready

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Holding register "cur" contains: cur_valid, cur_data[127:0], cur_len, cur_last, cur_addr.
- Reset (any time, including mid-block): cur_valid=0, cur_data=0, cur_len=0, cur_last=0, cur_addr=0, next-address counter naddr=0.
  - Resulting outputs: out_valid=0, out_last=0, out_len=0, out_addr=0, in_ready=1.
  - Any partially formed window is discarded; no window is emitted for beats accepted before reset.
- Output valid: out_valid = cur_valid & (cur_last | in_valid). This is combinational from in_valid, by design; out_valid never depends on out_ready.
- Output data:
  - cur_last=0: out_data = {cur_data, in_data[127:128-8*LA_BYTES]}.
  - cur_last=1: out_data = {cur_data, zeros}; lookahead bytes are zero.
  - out_addr, out_len and out_last come directly from cur.
- Input ready: in_ready = ~cur_valid | out_ready.
- Load into cur: an accepted input beat loads cur on the next clock edge.
  - The load occurs when cur is empty, or in the same cycle cur's window is transferred. The bubble-free case is cur non-last, in_valid=1, out_ready=1: the window fires and the new beat loads in the same cycle.
- cur_last=1 and out_ready=1 with in_valid=1: the last window fires and the new beat (start of the next block) loads simultaneously.
- cur_last=1 and in_valid=0 with out_ready=1: the last window fires and cur_valid clears.
- Stall: cur_valid=1, cur_last=0, in_valid=0. out_valid=0, cur holds, no input is consumed.
- Backpressure: out_valid=1, out_ready=0. All cur fields hold, in_ready=0, and out_data must remain stable for as long as in_data is held stable by the upstream valid/ready rule.
- Address:
  - On each beat load, cur_addr <= naddr.
  - naddr <= naddr+16 (mod 2^ADDR_W) for a non-last beat; naddr <= 0 for a last beat, so the next block starts at 0.
- Length:
  - cur_len <= in_last ? in_len : 16.
  - in_len=0 on a last beat is treated as 16.
- Latency: one beat of lookahead; a window appears in the cycle its successor beat is presented, or on the cycle after load if it is the last beat.

Optional Feature:
- Macro PREPARSER_WINDOW_STALL_CNT_EN.
- When defined: adds output port stall_cnt [31:0], the count of cycles with out_valid & ~out_ready.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst_n only.
- When undefined: no port and no counter; all other behaviour identical.

Test Plan:
- Single block, beats 0x00..0F and 0x10..1F (last, in_len=16), out_ready=1 → two windows:
  - Window 1: out_data=0x000102..0F1011, addr 0x00000, out_last=0.
  - Window 2: out_data=0x10..1F0000, addr 0x00010, out_last=1, out_len=16.
- Back-to-back 4 beats with no gaps, out_ready=1 → in_ready stays 1; windows on consecutive cycles after the first; addrs 0x00, 0x10, 0x20, 0x30.
- out_ready=0 for 5 cycles while out_valid=1 → in_ready=0, out_data/out_addr stable for all 5 cycles; with the macro defined, stall_cnt=5.
- Last beat with in_len=7, immediately followed by the next block's first beat → out_len=7, lookahead bytes zero; next block's first window has out_addr=0.
- Address wrap: feed 8192 beats with no last → the 8192nd window has out_addr=0x1FFF0, and the next has 0x00000.
- Assert rst_n=0 asynchronously between clock edges mid-block → out_valid falls immediately, in_ready=1; after release, the first beat's window has out_addr=0.
